// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer.
// - Access-size encodings as they arrive on req_size.
// - FSM state enum used by dmem_lsu_ctrl.
// - Alignment check applied when a request is accepted.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CAP,
      ST_WR,
      ST_RESP,
      ST_ERR
   } lsu_state_e;

   // A half must sit on an even byte, a word on a word boundary.
   // Size 2'b11 is never legal, whatever the offset.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
      logic ok;
      case (size)
         SZ_B:    ok = 1'b1;
         SZ_H:    ok = ~off[0];
         SZ_W:    ok = (off == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic for the load/store sequencer.
// Ports:
//   word_i     : word read from dmem
//   off_i      : byte offset of the request within that word
//   size_i     : access size (SZ_B / SZ_H / SZ_W)
//   unsigned_i : zero-extend loads when 1, sign-extend when 0
//   sdata_i    : right-aligned store data
//   ld_data_o  : extracted and extended load result
//   st_word_o  : word with the addressed lanes replaced by store data
// Lanes are little-endian: byte k is word[8k+7:8k], half h is word[16h+15:16h].
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] sdata_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] st_word_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [4:0]  byte_base;
   logic [4:0]  half_base;

   assign byte_base = {off_i, 3'b000};
   assign half_base = {off_i[1], 4'b0000};

   always_comb begin
      byte_sel = word_i[byte_base +: 8];
      half_sel = word_i[half_base +: 16];

      ld_data_o = word_i;
      case (size_i)
         SZ_B:    ld_data_o = unsigned_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         SZ_H:    ld_data_o = unsigned_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: ld_data_o = word_i;
      endcase

      // Untouched lanes keep the captured read data.
      st_word_o = word_i;
      case (size_i)
         SZ_B:    st_word_o[byte_base +: 8]  = sdata_i[7:0];
         SZ_H:    st_word_o[half_base +: 16] = sdata_i[15:0];
         default: st_word_o = sdata_i;
      endcase
   end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the core memory stage and a word-only dmem.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid / req_ready    : request handshake (ready only in IDLE)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                : request payload, latched at accept
//   resp_valid, resp_rdata,
//   resp_err                 : one-cycle completion pulse with result
//   MemRead, MemWrite, addr,
//   wdata, rdata             : dmem interface; rdata is valid the cycle
//                              after MemRead rises with addr held
// Sub-word stores are read-modify-write; misaligned or illegal-size
// requests get an error response without touching memory.
module dmem_lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] addr,
   output logic [31:0]       wdata,
   input  logic [31:0]       rdata
);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;

   // Request payload; only meaningful between accept and response.
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       sdata_q, sdata_d;

   logic [31:0]       ld_data;
   logic [31:0]       st_word;

   lsu_byte_lane u_lane (
      .word_i     (rdata),
      .off_i      (off_q),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .sdata_i    (sdata_q),
      .ld_data_o  (ld_data),
      .st_word_o  (st_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      sdata_q <= sdata_d;
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_rdata_d = resp_rdata_q;
      we_d         = we_q;
      size_d       = size_q;
      uns_d        = uns_q;
      off_d        = off_q;
      sdata_d      = sdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               off_d   = req_addr[1:0];
               sdata_d = req_wdata;
               if (!is_aligned(req_size, req_addr[1:0])) begin
                  // addr is left alone so a rejected request never shows on the bus
                  resp_rdata_d = '0;
                  state_d      = ST_ERR;
               end else begin
                  addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                  if (req_we && (req_size == SZ_W)) begin
                     wdata_d = req_wdata;
                     state_d = ST_WR;
                  end else begin
                     state_d = ST_RD;
                  end
               end
            end
         end
         ST_RD: begin
            state_d = ST_CAP;
         end
         ST_CAP: begin
            if (we_q) begin
               wdata_d = st_word;
               state_d = ST_WR;
            end else begin
               resp_rdata_d = ld_data;
               state_d      = ST_RESP;
            end
         end
         ST_WR: begin
            resp_rdata_d = '0;
            state_d      = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign MemRead    = (state_q == ST_RD) || (state_q == ST_CAP);
   assign MemWrite   = (state_q == ST_WR);
   assign resp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
   assign resp_err   = (state_q == ST_ERR);
   assign resp_rdata = resp_rdata_q;
   assign addr       = addr_q;
   assign wdata      = wdata_q;

endmodule
